// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
// Shared definitions for the approximate multiplier pipeline.
//   MAX_W / MAX_PW : largest supported operand width and product width.
//   cs_pair_t      : carry-save (sum, carry) pair carried from S2 to S3.
//                    Sized for MAX_W; narrower instances use the low
//                    2*WIDTH bits and leave the rest at zero.
//   level_ok()     : legality check for the WIDTH/LEVEL pair.
//   comp_const()   : mean-error compensation constant 2^(LEVEL-1).
`timescale 1ns/1ps
package approx_mult_pkg;

  localparam int MAX_W  = 32;
  localparam int MAX_PW = 2 * MAX_W;

  typedef struct packed {
    logic [MAX_PW-1:0] sum;
    logic [MAX_PW-1:0] carry;
  } cs_pair_t;

  function automatic bit level_ok(input int level, input int width);
    return (width >= 4) && (width <= MAX_W) &&
           (level >= 1) && (level <= 2 * width - 1);
  endfunction

  // Half of the weight of the first kept column: centres the truncation
  // error around zero for uniformly distributed operands.
  function automatic logic [MAX_PW-1:0] comp_const(input int level, input int width);
    logic [MAX_PW-1:0] c;
    c = '0;
    if (level_ok(level, width)) c[level-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/approx_pp_compress.sv
// approx_pp_compress
// Purely combinational partial-product generation, column masking and
// carry-save reduction down to two rows.
//   x, y    : unsigned operands (WIDTH bits)
//   approx  : 1 = drop every partial-product bit in a column below LEVEL
//   cs      : two rows whose sum (mod 2^(2*WIDTH)) is the product
`timescale 1ns/1ps
module approx_pp_compress
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEVEL = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             approx,
  output cs_pair_t         cs
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] col_mask;
  logic [PW-1:0] row [WIDTH];
  logic [PW-1:0] s_acc;
  logic [PW-1:0] c_acc;
  logic [PW-1:0] s_nxt;
  logic [PW-1:0] c_nxt;

  always_comb begin
    // Row i holds p(i,j) at column i+j, so masking whole columns is a
    // plain AND against one mask shared by every row.
    col_mask = approx ? ~((PW'(1) << LEVEL) - PW'(1)) : '1;
    for (int i = 0; i < WIDTH; i++) begin
      row[i] = (x[i] ? (PW'(y) << i) : '0) & col_mask;
    end

    // Chain of 3:2 compressors. Carries that fall off the top are
    // harmless: the true total always fits in PW bits.
    s_acc = row[0];
    c_acc = row[1];
    s_nxt = '0;
    c_nxt = '0;
    for (int i = 2; i < WIDTH; i++) begin
      s_nxt = s_acc ^ c_acc ^ row[i];
      c_nxt = ((s_acc & c_acc) | (s_acc & row[i]) | (c_acc & row[i])) << 1;
      s_acc = s_nxt;
      c_acc = c_nxt;
    end

    cs = '0;
    cs.sum[PW-1:0]   = s_acc;
    cs.carry[PW-1:0] = c_acc;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
// Three-stage pipelined unsigned multiplier with a per-transaction
// exact/approximate mode, sideband tag and saturating approximate counter.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (x, y, approx, in_tag)
//   out_valid/out_ready : result handshake (z, out_tag, out_approx)
//   approx_cnt          : number of approximate results delivered
// Build option: define APPROX_MULT_COMP_EN to add 2^(LEVEL-1) to
// approximate results; exact results are unaffected either way.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// valid, once raised, holds with its payload until that transfer;
// ready may depend combinationally on the downstream ready.
`timescale 1ns/1ps
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEVEL = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               approx,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_approx,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int PW = 2 * WIDTH;

  if (!level_ok(LEVEL, WIDTH)) begin : g_bad_params
    $error("approx_mult_pipe: illegal WIDTH/LEVEL combination");
  end

  // Stage registers
  logic               s1_valid;
  logic [WIDTH-1:0]   s1_x;
  logic [WIDTH-1:0]   s1_y;
  logic               s1_approx;
  logic [TAG_W-1:0]   s1_tag;

  logic               s2_valid;
  cs_pair_t           s2_cs;
  logic               s2_approx;
  logic [TAG_W-1:0]   s2_tag;

  logic               s3_valid;
  logic [PW-1:0]      s3_z;
  logic               s3_approx;
  logic [TAG_W-1:0]   s3_tag;

  logic [CNT_W-1:0]   cnt_q;

  // Combinational
  cs_pair_t           cs_comb;
  logic [MAX_PW-1:0]  sum_full;
  logic               s1_load;
  logic               s2_load;
  logic               s3_load;

  // A stage may load when it is empty or its content leaves this cycle;
  // the chain makes in_ready combinational from out_ready.
  assign s3_load  = !s3_valid || out_ready;
  assign s2_load  = !s2_valid || s3_load;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  approx_pp_compress #(
    .WIDTH (WIDTH),
    .LEVEL (LEVEL)
  ) u_compress (
    .x      (s1_x),
    .y      (s1_y),
    .approx (s1_approx),
    .cs     (cs_comb)
  );

  always_comb begin
    sum_full = s2_cs.sum + s2_cs.carry;
`ifdef APPROX_MULT_COMP_EN
    if (s2_approx) sum_full = sum_full + comp_const(LEVEL, WIDTH);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_approx <= 1'b0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_cs     <= '0;
      s2_approx <= 1'b0;
      s2_tag    <= '0;
      s3_valid  <= 1'b0;
      s3_z      <= '0;
      s3_approx <= 1'b0;
      s3_tag    <= '0;
      cnt_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_x      <= x;
          s1_y      <= y;
          s1_approx <= approx;
          s1_tag    <= in_tag;
        end
      end

      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_cs     <= cs_comb;
          s2_approx <= s1_approx;
          s2_tag    <= s1_tag;
        end
      end

      // Output payload only changes on a load, so it holds under stall.
      if (s3_load) begin
        s3_valid <= s2_valid;
        if (s2_valid) begin
          s3_z      <= sum_full[PW-1:0];
          s3_approx <= s2_approx;
          s3_tag    <= s2_tag;
        end
      end

      if (s3_valid && out_ready && s3_approx && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid  = s3_valid;
  assign z          = s3_z;
  assign out_tag    = s3_tag;
  assign out_approx = s3_approx;
  assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
`timescale 1ns/1ps
module tb_approx_mult_pipe;

  localparam int W  = 8;
  localparam int L  = 8;
  localparam int TW = 4;
  localparam int CW = 4;
  localparam int PW = 2 * W;
  localparam int EW = PW + TW + 1;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          approx;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] z;
  logic [TW-1:0] out_tag;
  logic          out_approx;
  logic [CW-1:0] approx_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: {approx, tag, z} per accepted operand, oldest first
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  approx_mult_pipe #(
    .WIDTH (W),
    .LEVEL (L),
    .TAG_W (TW),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .approx     (approx),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z          (z),
    .out_tag    (out_tag),
    .out_approx (out_approx),
    .approx_cnt (approx_cnt)
  );

  // Reference: sum of kept partial-product bits, bit by bit
  function automatic logic [PW-1:0] ref_mult(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic ap);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && (!ap || (i + j) >= L)) acc = acc + (PW'(1) << (i + j));
`ifdef APPROX_MULT_COMP_EN
    if (ap) acc = acc + (PW'(1) << (L - 1));
`endif
    return acc;
  endfunction

  // Driver
  task automatic drive(input logic v, input logic [W-1:0] xx, input logic [W-1:0] yy,
                       input logic ap, input logic [TW-1:0] tg, input logic ordy);
    in_valid  = v;
    x         = xx;
    y         = yy;
    approx    = ap;
    in_tag    = tg;
    out_ready = ordy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (z !== '0) $display("FAIL reset_z: got %0d want 0", z); else n_pass++;
    n_checks++; if (out_tag !== '0) $display("FAIL reset_out_tag: got %0d want 0", out_tag); else n_pass++;
    n_checks++; if (out_approx !== 1'b0) $display("FAIL reset_out_approx: got %b want 0", out_approx); else n_pass++;
    n_checks++; if (approx_cnt !== '0) $display("FAIL reset_approx_cnt: got %0d want 0", approx_cnt); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int vx[7] = '{255, 255, 15, 16, 1,   13, 3};
    int vy[7] = '{255, 255, 15, 16, 128, 11, 192};
    int va[7] = '{0,   1,   1,  1,  1,   0,  1};
`ifdef APPROX_MULT_COMP_EN
    int vz[7] = '{65025, 63360, 128, 384, 128, 143, 384};
`else
    int vz[7] = '{65025, 63232, 0,   256, 0,   143, 256};
`endif
    int t0;
    int waited;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drive(1'b1, W'(vx[k]), W'(vy[k]), 1'(va[k]), TW'(k + 1), 1'b1);
      t0 = cyc;
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      waited = 0;
      while (!out_valid && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      n_checks++; if (out_valid !== 1'b1) $display("FAIL dir_timeout[%0d]: got out_valid %b want 1", k, out_valid); else n_pass++;
      n_checks++; if (cyc - t0 !== 3) $display("FAIL dir_latency[%0d]: got %0d want 3", k, cyc - t0); else n_pass++;
      n_checks++; if (z !== PW'(vz[k])) $display("FAIL dir_z[%0d]: got %0d want %0d", k, z, vz[k]); else n_pass++;
      n_checks++; if (out_tag !== TW'(k + 1)) $display("FAIL dir_tag[%0d]: got %0d want %0d", k, out_tag, k + 1); else n_pass++;
      n_checks++; if (out_approx !== 1'(va[k])) $display("FAIL dir_approx[%0d]: got %b want %0d", k, out_approx, va[k]); else n_pass++;
    end
  endtask

  task automatic test_throughput;
    int sent = 0;
    int recv = 0;
    int stalls = 0;
    int t;
    logic [EW-1:0] e;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int c = 0; c < 300 && recv < 100; c++) begin
      @(negedge clk);
      if (sent < 100)
        drive(1'b1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)), 1'b1);
      else
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL tp_spurious: got z %0d want no output", z);
        end else begin
          e = exp_q.pop_front();
          t = exp_cyc_q.pop_front();
          n_checks++; if ({out_approx, out_tag, z} !== e) $display("FAIL tp_data[%0d]: got z %0d tag %0d ap %b want z %0d tag %0d ap %b", recv, z, out_tag, out_approx, e[PW-1:0], e[PW+TW-1:PW], e[EW-1]); else n_pass++;
          n_checks++; if (cyc !== t) $display("FAIL tp_latency[%0d]: got cycle %0d want %0d", recv, cyc, t); else n_pass++;
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({approx, in_tag, ref_mult(x, y, approx)});
        exp_cyc_q.push_back(cyc + 3);
        sent++;
      end else if (in_valid) begin
        stalls++;
      end
    end
    n_checks++; if (recv !== 100) $display("FAIL tp_count: got %0d want 100", recv); else n_pass++;
    n_checks++; if (stalls !== 0) $display("FAIL tp_stalls: got %0d want 0", stalls); else n_pass++;
  endtask

  task automatic test_back_pressure;
    int acc = 0;
    int recv = 0;
    logic held = 1'b0;
    logic [EW-1:0] held_v;
    logic [EW-1:0] e;
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b1, W'(c * 17 + 3), W'(c * 29 + 5), 1'(c % 2), TW'(c + 2), 1'b0);
      #1;
      n_checks++; if (in_ready !== (acc < 3)) $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, (acc < 3)); else n_pass++;
      if (held) begin
        n_checks++; if (out_valid !== 1'b1 || {out_approx, out_tag, z} !== held_v) $display("FAIL bp_hold[%0d]: got v %b z %0d want v 1 z %0d", c, out_valid, z, held_v[PW-1:0]); else n_pass++;
      end else if (out_valid) begin
        held = 1'b1;
        held_v = {out_approx, out_tag, z};
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({approx, in_tag, ref_mult(x, y, approx)});
        acc++;
      end
    end
    n_checks++; if (acc !== 3) $display("FAIL bp_accepted: got %0d want 3", acc); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL bp_duplicate: got z %0d want no output", z);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if ({out_approx, out_tag, z} !== e) $display("FAIL bp_data[%0d]: got z %0d tag %0d want z %0d tag %0d", recv, z, out_tag, e[PW-1:0], e[PW+TW-1:PW]); else n_pass++;
        end
        recv++;
      end
    end
    n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_loss: got %0d left want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midstream;
    int t0;
    int waited;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, W'(200 + c), W'(100), 1'b1, TW'(c + 9), 1'b1);
    end
    // Three in flight, head offered at the output, new operand offered too
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, W'(9), W'(9), 1'b1, TW'(7), 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (approx_cnt !== '0) $display("FAIL rst_mid_cnt: got %0d want 0", approx_cnt); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_flushed: got %b want 0", out_valid); else n_pass++;
    drive(1'b1, W'(255), W'(255), 1'b1, TW'(5), 1'b1);
    t0 = cyc;
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (cyc - t0 !== 3) $display("FAIL rst_mid_latency: got %0d want 3", cyc - t0); else n_pass++;
    n_checks++; if (z !== ref_mult(W'(255), W'(255), 1'b1)) $display("FAIL rst_mid_z: got %0d want %0d", z, ref_mult(W'(255), W'(255), 1'b1)); else n_pass++;
    n_checks++; if (out_tag !== TW'(5)) $display("FAIL rst_mid_tag: got %0d want 5", out_tag); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_counter;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (approx_cnt !== '0) $display("FAIL cnt_start: got %0d want 0", approx_cnt); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, W'(i + 1), W'(3), 1'b1, TW'(i), 1'b1);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++; if (approx_cnt !== CW'(5)) $display("FAIL cnt_five: got %0d want 5", approx_cnt); else n_pass++;
    // 15 more approximate, 5 exact: 20 approximate total saturates at 15
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, W'(i + 7), W'(i + 11), 1'((i % 4) != 3), TW'(i), 1'b1);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (6) @(negedge clk);
    n_checks++; if (approx_cnt !== CW'(15)) $display("FAIL cnt_saturate: got %0d want 15", approx_cnt); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_throughput();
    test_back_pressure();
    test_reset_midstream();
    test_counter();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
